// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared seven-segment codes for the clock display path
package clock_pkg;

   // Active-high segment view {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD nibble to seven-segment decoder, non-BCD shows a dash
module bcd_to_seg7
   import clock_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - multiplexed seven-segment scanner with frame snapshot, blink and blanking
module bcd_scan_display
   import clock_pkg::*;
#(
   parameter int NDIG         = 6,
   parameter int DIV          = 1000,
   parameter int BLINK_FRAMES = 64,
   parameter int ACT_LOW      = 1,
   parameter int LZB          = 1
)
(
   input  logic                CP,
   input  logic                nCLR,
   input  logic                EN,
   input  logic [4*NDIG-1:0]   digits,
   input  logic [NDIG-1:0]     blink_mask,
   input  logic [NDIG-1:0]     dp_mask,
   output logic [6:0]          seg,
   output logic                dp,
   output logic [NDIG-1:0]     an,
   output logic                frame_done
);

   localparam int PW = $clog2(DIV);
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int BW = $clog2(BLINK_FRAMES + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);
   localparam logic [BW-1:0] BCNT_LAST  = BW'(BLINK_FRAMES - 1);
   localparam logic          INV        = (ACT_LOW != 0);
   localparam logic          LZB_ON     = (LZB != 0);

   logic [PW-1:0]     presc;
   logic [IW-1:0]     idx;
   logic              started;
   logic [4*NDIG-1:0] digits_snap;
   logic [NDIG-1:0]   blink_snap;
   logic [NDIG-1:0]   dp_snap;
   logic              blink_on;
   logic [BW-1:0]     blink_cnt;
   logic [6:0]        seg_q;
   logic              dp_q;
   logic [NDIG-1:0]   an_q;

   logic              tick;
   logic              wrap;
   logic [IW-1:0]     next_idx;
   logic [4*NDIG-1:0] next_digits;
   logic [NDIG-1:0]   next_blink;
   logic [NDIG-1:0]   next_dp;
   logic              next_blink_on;
   logic [BW-1:0]     next_blink_cnt;
   logic [3:0]        nibble;
   logic [6:0]        dec_seg;
   logic              blank;
   logic [6:0]        seg_d;
   logic              dp_d;
   logic [NDIG-1:0]   an_d;

   // Outputs are decoded from the post-edge index and snapshot so they need no extra stage.
   always_comb begin
      tick           = EN && (presc == PRESC_LAST);
      wrap           = tick && (idx == IDX_LAST);
      frame_done     = wrap && started;
      next_idx       = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      next_digits    = wrap ? digits     : digits_snap;
      next_blink     = wrap ? blink_mask : blink_snap;
      next_dp        = wrap ? dp_mask    : dp_snap;
      next_blink_on  = blink_on;
      next_blink_cnt = blink_cnt;
      if (frame_done) begin
         if (blink_cnt == BCNT_LAST) begin
            next_blink_on  = ~blink_on;
            next_blink_cnt = '0;
         end else begin
            next_blink_cnt = blink_cnt + 1'b1;
         end
      end
      nibble = next_digits[{next_idx, 2'b00} +: 4];
      blank  = (!next_blink_on && next_blink[next_idx]) ||
               (LZB_ON && (next_idx == IDX_LAST) && (nibble == 4'd0));
      seg_d  = blank ? SEG_BLANK : dec_seg;
      dp_d   = !blank && next_dp[next_idx];
      an_d   = '0;
      for (int i = 0; i < NDIG; i++) begin
         an_d[i] = (next_idx == IW'(i));
      end
   end

   bcd_to_seg7 u_dec (
      .bcd (nibble),
      .seg (dec_seg)
   );

   always_ff @(posedge CP or negedge nCLR) begin
      if (!nCLR) begin
         presc       <= '0;
         idx         <= IDX_LAST;
         started     <= 1'b0;
         digits_snap <= '0;
         blink_snap  <= '0;
         dp_snap     <= '0;
         blink_on    <= 1'b1;
         blink_cnt   <= '0;
         seg_q       <= '0;
         dp_q        <= 1'b0;
         an_q        <= '0;
      end else if (EN) begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick) begin
            idx         <= next_idx;
            started     <= 1'b1;
            digits_snap <= next_digits;
            blink_snap  <= next_blink;
            dp_snap     <= next_dp;
            blink_on    <= next_blink_on;
            blink_cnt   <= next_blink_cnt;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
         end
      end
   end

   assign seg = seg_q ^ {7{INV}};
   assign dp  = dp_q ^ INV;
   assign an  = an_q ^ {NDIG{INV}};

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - directed self-checking bench for bcd_scan_display
module tb_bcd_scan_display;

   logic        CP = 1'b0;
   logic        nCLR = 1'b0;
   logic        EN = 1'b0;
   logic [23:0] digits = '0;
   logic [5:0]  blink_mask = '0;
   logic [5:0]  dp_mask = '0;
   logic [6:0]  seg;
   logic        dp;
   logic [5:0]  an;
   logic        frame_done;
   int          tests_run = 0;
   int          tests_failed = 0;

   bcd_scan_display #(
      .NDIG(6), .DIV(4), .BLINK_FRAMES(2), .ACT_LOW(0), .LZB(1)
   ) dut (
      .CP(CP), .nCLR(nCLR), .EN(EN), .digits(digits),
      .blink_mask(blink_mask), .dp_mask(dp_mask),
      .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
   );

   always #5 CP = ~CP;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step(input int n);
      repeat (n) @(posedge CP);
      @(negedge CP);
   endtask

   task automatic apply_reset(input logic [23:0] d, input logic [5:0] bm, input logic [5:0] dm);
      nCLR = 1'b0; EN = 1'b1; digits = d; blink_mask = bm; dp_mask = dm;
      @(negedge CP);
      @(negedge CP);
      nCLR = 1'b1;
   endtask

   task automatic test_reset;
      nCLR = 1'b0; EN = 1'b1; digits = 24'h235959; blink_mask = '0; dp_mask = '0;
      @(negedge CP);
      tests_run++; if (an !== 6'b000000) begin tests_failed++; $display("FAIL reset_an: got %b required 000000", an); end
      tests_run++; if (seg !== 7'h00) begin tests_failed++; $display("FAIL reset_seg: got %h required 00", seg); end
      tests_run++; if (dp !== 1'b0) begin tests_failed++; $display("FAIL reset_dp: got %b required 0", dp); end
      tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_fd: got %b required 0", frame_done); end
      @(negedge CP);
      nCLR = 1'b1;
      step(3);
      tests_run++; if (an !== 6'b000000) begin tests_failed++; $display("FAIL pre_tick_an: got %b required 000000", an); end
      tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL first_wrap_no_pulse: got %b required 0", frame_done); end
      step(1);
      tests_run++; if (an !== 6'b000001) begin tests_failed++; $display("FAIL tick1_an: got %b required 000001", an); end
      tests_run++; if (seg !== 7'h6F) begin tests_failed++; $display("FAIL tick1_seg: got %h required 6f", seg); end
      step(4);
      tests_run++; if (an !== 6'b000010) begin tests_failed++; $display("FAIL tick2_an: got %b required 000010", an); end
      tests_run++; if (seg !== 7'h6D) begin tests_failed++; $display("FAIL tick2_seg: got %h required 6d", seg); end
   endtask

   task automatic test_scan;
      int pulses = 0;
      int pos = -1;
      step(16);
      tests_run++; if (an !== 6'b100000) begin tests_failed++; $display("FAIL idx5_an: got %b required 100000", an); end
      tests_run++; if (seg !== 7'h5B) begin tests_failed++; $display("FAIL idx5_seg: got %h required 5b", seg); end
      for (int i = 0; i < 4; i++) begin
         if (frame_done === 1'b1) begin pulses++; pos = i; end
         if (i < 3) step(1);
      end
      tests_run++; if (pulses != 1) begin tests_failed++; $display("FAIL fd_count: got %0d required 1", pulses); end
      tests_run++; if (pos != 3) begin tests_failed++; $display("FAIL fd_pos: got %0d required 3", pos); end
      step(1);
      tests_run++; if (an !== 6'b000001) begin tests_failed++; $display("FAIL wrap_an: got %b required 000001", an); end
   endtask

   task automatic test_snapshot;
      apply_reset(24'h235959, '0, '0);
      step(12);
      tests_run++; if (an !== 6'b000100 || seg !== 7'h6F) begin tests_failed++; $display("FAIL snap_idx2: got an=%b seg=%h required 000100 6f", an, seg); end
      digits = 24'h000000;
      step(4);
      tests_run++; if (seg !== 7'h6D) begin tests_failed++; $display("FAIL snap_idx3: got %h required 6d", seg); end
      step(4);
      tests_run++; if (seg !== 7'h4F) begin tests_failed++; $display("FAIL snap_idx4: got %h required 4f", seg); end
      step(4);
      tests_run++; if (seg !== 7'h5B) begin tests_failed++; $display("FAIL snap_idx5: got %h required 5b", seg); end
      step(4);
      tests_run++; if (an !== 6'b000001 || seg !== 7'h3F) begin tests_failed++; $display("FAIL new_frame_idx0: got an=%b seg=%h required 000001 3f", an, seg); end
      step(12);
      tests_run++; if (seg !== 7'h3F) begin tests_failed++; $display("FAIL new_frame_idx3: got %h required 3f", seg); end
      step(8);
      tests_run++; if (an !== 6'b100000 || seg !== 7'h00) begin tests_failed++; $display("FAIL lzb_idx5: got an=%b seg=%h required 100000 00", an, seg); end
   endtask

   task automatic test_invalid_dp;
      apply_reset(24'h23595A, '0, 6'b000100);
      step(4);
      tests_run++; if (seg !== 7'h40) begin tests_failed++; $display("FAIL dash_seg: got %h required 40", seg); end
      tests_run++; if (dp !== 1'b0) begin tests_failed++; $display("FAIL dp_idx0: got %b required 0", dp); end
      step(8);
      tests_run++; if (an !== 6'b000100 || dp !== 1'b1) begin tests_failed++; $display("FAIL dp_idx2: got an=%b dp=%b required 000100 1", an, dp); end
      step(4);
      tests_run++; if (dp !== 1'b0) begin tests_failed++; $display("FAIL dp_idx3: got %b required 0", dp); end
   endtask

   task automatic test_blink;
      logic blank;
      apply_reset(24'h235959, 6'b000001, 6'b000001);
      step(4);
      for (int f = 0; f < 6; f++) begin
         blank = (f == 2) || (f == 3);
         tests_run++;
         if (seg !== (blank ? 7'h00 : 7'h6F) || dp !== !blank) begin
            tests_failed++;
            $display("FAIL blink_frame%0d: got seg=%h dp=%b required %h %b", f, seg, dp, blank ? 7'h00 : 7'h6F, !blank);
         end
         if (f < 5) step(24);
      end
   endtask

   task automatic test_hold_async;
      apply_reset(24'h235959, '0, '0);
      step(10);
      tests_run++; if (an !== 6'b000010) begin tests_failed++; $display("FAIL pre_hold_an: got %b required 000010", an); end
      EN = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         tests_run++;
         if ({an, seg, frame_done} !== {6'b000010, 7'h6D, 1'b0}) begin
            tests_failed++;
            $display("FAIL hold_c%0d: got an=%b seg=%h fd=%b required 000010 6d 0", i, an, seg, frame_done);
         end
      end
      EN = 1'b1;
      step(1);
      tests_run++; if (an !== 6'b000010) begin tests_failed++; $display("FAIL resume_presc: got %b required 000010", an); end
      step(1);
      tests_run++; if (an !== 6'b000100 || seg !== 7'h6F) begin tests_failed++; $display("FAIL resume_tick: got an=%b seg=%h required 000100 6f", an, seg); end
      #2 nCLR = 1'b0;
      #1;
      tests_run++; if ({an, seg, dp} !== 14'b0) begin tests_failed++; $display("FAIL async_reset: got an=%b seg=%h dp=%b required 0 0 0", an, seg, dp); end
      @(negedge CP);
      nCLR = 1'b1;
      step(3);
      tests_run++; if (an !== 6'b000000) begin tests_failed++; $display("FAIL restart_pre: got %b required 000000", an); end
      step(1);
      tests_run++; if (an !== 6'b000001) begin tests_failed++; $display("FAIL restart_tick: got %b required 000001", an); end
   endtask

   initial begin
      test_reset;
      test_scan;
      test_snapshot;
      test_invalid_dp;
      test_blink;
      test_hold_async;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
